// File: rtl/gnn_0_buffer_loader_pkg.sv
// gnn_0_buffer_loader_pkg: shared state encoding, instruction field layout and decoder.
package gnn_loader_pkg;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_STREAM, S_FINISH} state_e;

    localparam int BANK_LSB      = 0;
    localparam int BANK_W        = 4;
    localparam int BCAST_BIT     = 4;
    localparam int BUF_START_LSB = 32;
    localparam int LEN_LSB       = 48;
    localparam int DRAM_LSB      = 64;
    localparam int BYTES_LSB     = 80;
    localparam int FIELD_W       = 16;

    typedef struct packed {
        logic [BANK_W-1:0]  bank;
        logic               bcast;
        logic [FIELD_W-1:0] buf_start;
        logic [FIELD_W-1:0] len;
        logic [FIELD_W-1:0] dram_start;
        logic [FIELD_W-1:0] bytes;
    } inst_t;

    function automatic inst_t decode_inst(input logic [95:0] inst);
        inst_t d;
        d.bank       = inst[BANK_LSB +: BANK_W];
        d.bcast      = inst[BCAST_BIT];
        d.buf_start  = inst[BUF_START_LSB +: FIELD_W];
        d.len        = inst[LEN_LSB +: FIELD_W];
        d.dram_start = inst[DRAM_LSB +: FIELD_W];
        d.bytes      = inst[BYTES_LSB +: FIELD_W];
        return d;
    endfunction

endpackage

// File: rtl/gnn_0_buffer_loader_if.sv
// gnn_0_buffer_loader_if: ctrl, AXI read-master, beat stream and buffer-write signals of the loader.
interface gnn_0_buffer_loader_if #(
    parameter int INST_LENGTH        = 96,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int BUF_ADDR_WIDTH     = 9,
    parameter int NUM_BANKS          = 4
);
    logic                          ap_start;
    logic                          ap_done;
    logic                          busy;
    logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset;
    logic [INST_LENGTH-1:0]        ctrl_instruction;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes;
    logic                          read_start;
    logic                          read_done;
    logic                          data_tvalid;
    logic                          data_tready;
    logic                          data_tlast;
    logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata;
    logic [NUM_BANKS-1:0]          buf_wr_valid;
    logic [BUF_ADDR_WIDTH-1:0]     buf_wr_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data;
    logic                          overflow_err;

    modport master (
        input  ap_start, ctrl_addr_offset, ctrl_instruction, read_done,
               data_tvalid, data_tlast, data_tdata,
        output ap_done, busy, dram_xfer_start_addr, dram_xfer_size_in_bytes, read_start,
               data_tready, buf_wr_valid, buf_wr_addr, buf_wr_data, overflow_err
    );

    modport slave (
        output ap_start, ctrl_addr_offset, ctrl_instruction, read_done,
               data_tvalid, data_tlast, data_tdata,
        input  ap_done, busy, dram_xfer_start_addr, dram_xfer_size_in_bytes, read_start,
               data_tready, buf_wr_valid, buf_wr_addr, buf_wr_data, overflow_err
    );

endinterface

// File: rtl/gnn_0_buffer_loader_wr_stage.sv
// gnn_loader_wr_stage: one-cycle registered buffer write port driven by accepted in-range beats.
module gnn_loader_wr_stage #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 512,
    parameter int NUM_BANKS = 4
) (
    input  logic                 kernel_clk,
    input  logic                 kernel_rst,
    input  logic                 accept_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    data_i,
    input  logic [NUM_BANKS-1:0] mask_i,
    output logic [NUM_BANKS-1:0] wr_valid_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [DATA_W-1:0]    wr_data_o
);
    logic [NUM_BANKS-1:0] valid_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= accept_i ? mask_i : '0;
            if (accept_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign wr_valid_o = valid_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;

endmodule

// File: rtl/gnn_0_buffer_loader.sv
// gnn_0_buffer_loader: decodes a load instruction, issues one AXI read and streams
// the returned beats into one bank or all banks of the on-chip buffer.
module gnn_0_buffer_loader
    import gnn_loader_pkg::*;
#(
    parameter int INST_LENGTH        = 96,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int BUF_ADDR_WIDTH     = 9,
    parameter int NUM_BANKS          = 4
) (
    input logic                   kernel_clk,
    input logic                   kernel_rst,
    gnn_0_buffer_loader_if.master bus
);
    state_e                        state_q, state_d;
    inst_t                         inst_q, inst_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [FIELD_W-1:0]            count_q, count_d;
    logic                          rd_done_q, rd_done_d;
    logic                          ovf_q, ovf_d;
    logic                          accept, in_range, wr_acc;
    logic [NUM_BANKS-1:0]          bank_mask;
    logic [BUF_ADDR_WIDTH-1:0]     wr_addr;
    logic                          unused_ok;

    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state_q   <= S_IDLE;
            inst_q    <= '0;
            offset_q  <= '0;
            count_q   <= '0;
            rd_done_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            offset_q  <= offset_d;
            count_q   <= count_d;
            rd_done_q <= rd_done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign accept   = bus.data_tvalid && (state_q == S_STREAM);
    assign in_range = count_q < inst_q.len;

    // count only advances on in-range beats so count==len stays reachable with surplus traffic
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        offset_d  = offset_q;
        count_d   = count_q;
        rd_done_d = rd_done_q;
        ovf_d     = ovf_q;
        wr_acc    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.ap_start) begin
                inst_d      = decode_inst(bus.ctrl_instruction[95:0]);
                inst_d.bank = inst_d.bank & BANK_W'(NUM_BANKS - 1);
                offset_d    = bus.ctrl_addr_offset;
                count_d     = '0;
                rd_done_d   = 1'b0;
                ovf_d       = 1'b0;
                state_d     = S_DECODE;
            end
            S_DECODE: state_d = (inst_q.len == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:  state_d = S_STREAM;
            S_STREAM: begin
                wr_acc = accept && in_range;
                if (wr_acc) count_d = count_q + 16'd1;
                if (accept && !in_range) ovf_d = 1'b1;
                if (count_q == inst_q.len && rd_done_q) state_d = S_FINISH;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && bus.read_done) rd_done_d = 1'b1;
    end

    assign bank_mask = inst_q.bcast ? '1 : NUM_BANKS'(1) << inst_q.bank;
    assign wr_addr   = inst_q.buf_start[BUF_ADDR_WIDTH-1:0] + count_q[BUF_ADDR_WIDTH-1:0];

    gnn_loader_wr_stage #(
        .ADDR_W   (BUF_ADDR_WIDTH),
        .DATA_W   (C_M_AXI_DATA_WIDTH),
        .NUM_BANKS(NUM_BANKS)
    ) u_wr (
        .kernel_clk(kernel_clk),
        .kernel_rst(kernel_rst),
        .accept_i  (wr_acc),
        .addr_i    (wr_addr),
        .data_i    (bus.data_tdata),
        .mask_i    (bank_mask),
        .wr_valid_o(bus.buf_wr_valid),
        .wr_addr_o (bus.buf_wr_addr),
        .wr_data_o (bus.buf_wr_data)
    );

    assign bus.ap_done                 = state_q == S_FINISH;
    assign bus.busy                    = state_q != S_IDLE;
    assign bus.read_start              = state_q == S_ISSUE;
    assign bus.data_tready             = state_q == S_STREAM;
    assign bus.overflow_err            = ovf_q;
    assign bus.dram_xfer_start_addr    = offset_q + C_M_AXI_ADDR_WIDTH'(inst_q.dram_start);
    assign bus.dram_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(inst_q.bytes);

    assign unused_ok = ^{bus.data_tlast, bus.ctrl_instruction, inst_q};

endmodule

// File: tb/tb_gnn_0_buffer_loader.sv
// tb_gnn_0_buffer_loader: table-driven load operations with a write scoreboard,
// plus hand-written reset-mid-stream sequence.
module tb_gnn_0_buffer_loader;

    localparam logic [63:0] OFF = 64'h0000_1000_0000_0000;

    typedef struct {
        logic [3:0]  bank;
        logic        bcast;
        logic [15:0] start;
        logic [15:0] len;
        int          extra;
        int          rd_mode;
        bit          gaps;
        bit          poke;
        logic [3:0]  exp_mask;
        logic        exp_ovf;
        int          exp_rs;
    } vec_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [8:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gnn_0_buffer_loader_if bus ();

    gnn_0_buffer_loader dut (
        .kernel_clk(clk),
        .kernel_rst(rst),
        .bus       (bus)
    );

    int  checks = 0, failures = 0;
    int  cyc = 0, rs_cnt = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0;
    wr_t sbq[$];
    vec_t tv[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int op, input int i);
        logic [63:0] w;
        w = {32'(op), 32'(i)} ^ 64'hC0DE_0000_BEEF_0000;
        return {8{w}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            wr_t e;
            rs_cnt   += int'(bus.read_start);
            busy_cnt += int'(bus.busy);
            if (bus.ap_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.buf_wr_valid != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: mask %0h addr %0h, none expected", bus.buf_wr_valid, bus.buf_wr_addr);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_mask", 64'(bus.buf_wr_valid), 64'(e.mask));
                    chk("wr_addr", 64'(bus.buf_wr_addr), 64'(e.addr));
                    chk("wr_data", bus.buf_wr_data[63:0], e.data);
                end
            end
        end
    end

    task automatic do_op(input vec_t v, input int id);
        logic [95:0]  inst;
        logic [511:0] p;
        wr_t          e;
        int           r0, d0, w, last_beat, start_cyc;
        inst        = '0;
        inst[31:5]  = 27'h5A5A5A5;
        inst[3:0]   = v.bank;
        inst[4]     = v.bcast;
        inst[47:32] = v.start;
        inst[63:48] = v.len;
        inst[79:64] = 16'hA000 ^ v.start;
        inst[95:80] = v.len << 6;
        for (int i = 0; i < int'(v.len); i++) begin
            p      = pat(id, i);
            e.mask = v.exp_mask;
            e.addr = 9'(v.start + 16'(i));
            e.data = p[63:0];
            sbq.push_back(e);
        end
        r0        = rs_cnt;
        d0        = done_cnt;
        busy_cnt  = 0;
        last_beat = 0;
        bus.ctrl_instruction = inst;
        bus.ap_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.ap_start = 1'b0;
        chk("busy_decode", 64'(bus.busy), 64'd1);
        chk("ovf_cleared", 64'(bus.overflow_err), 64'd0);
        chk("dram_addr", bus.dram_xfer_start_addr, OFF + 64'(16'hA000 ^ v.start));
        chk("dram_bytes", 64'(bus.dram_xfer_size_in_bytes), 64'(16'(v.len << 6)));
        if (v.len != 0) begin
            w = 0;
            while (!bus.data_tready && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            chk("tready_wait", 64'(bus.data_tready), 64'd1);
            if (v.rd_mode == 1) begin
                bus.read_done = 1'b1;
                @(posedge clk); #1;
                bus.read_done = 1'b0;
            end
            for (int i = 0; i < int'(v.len) + v.extra; i++) begin
                if (v.gaps && i > 0 && i < int'(v.len)) begin
                    @(posedge clk); #1;
                end
                if (i < int'(v.len)) begin
                    chk("tready_beat", 64'(bus.data_tready), 64'd1);
                    last_beat = cyc;
                end
                bus.data_tvalid = 1'b1;
                bus.data_tdata  = pat(id, i);
                bus.data_tlast  = (i == int'(v.len) - 1);
                bus.read_done   = (v.rd_mode == 0 && i == int'(v.len) - 1);
                if (v.poke && i == 1) begin
                    bus.ap_start = 1'b1;
                    bus.ctrl_instruction = ~inst;
                end
                @(posedge clk); #1;
                bus.data_tvalid = 1'b0;
                bus.data_tlast  = 1'b0;
                bus.read_done   = 1'b0;
                bus.ap_start    = 1'b0;
            end
        end
        w = 0;
        while (done_cnt == d0 && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ap_done_count", 64'(done_cnt - d0), 64'd1);
        chk("read_start_count", 64'(rs_cnt - r0), 64'(v.exp_rs));
        chk("ap_done_latency", 64'(done_cyc - (v.len == 0 ? start_cyc : last_beat)), 64'd2);
        chk("writes_pending", 64'(sbq.size()), 64'd0);
        chk("overflow", 64'(bus.overflow_err), 64'(v.exp_ovf));
        if (v.len == 0) chk("busy_cycles", 64'(busy_cnt), 64'd2);
        if (v.poke) begin
            repeat (4) @(posedge clk);
            #1;
            chk("poke_idle", 64'(bus.busy), 64'd0);
            chk("poke_no_rerun", 64'(done_cnt - d0), 64'd1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        tv[0] = '{4'd2, 1'b0, 16'h010, 16'd4, 0, 0, 1'b0, 1'b0, 4'b0100, 1'b0, 1};
        tv[1] = '{4'd1, 1'b1, 16'h1FE, 16'd4, 0, 0, 1'b0, 1'b0, 4'b1111, 1'b0, 1};
        tv[2] = '{4'd0, 1'b0, 16'h020, 16'd0, 0, 0, 1'b0, 1'b0, 4'b0001, 1'b0, 0};
        tv[3] = '{4'd3, 1'b0, 16'h100, 16'd3, 2, 1, 1'b1, 1'b0, 4'b1000, 1'b1, 1};
        tv[4] = '{4'd6, 1'b0, 16'h005, 16'd2, 0, 0, 1'b0, 1'b0, 4'b0100, 1'b0, 1};
        tv[5] = '{4'd1, 1'b0, 16'h040, 16'd3, 0, 0, 1'b0, 1'b1, 4'b0010, 1'b0, 1};
        bus.ap_start         = 1'b0;
        bus.ctrl_addr_offset = OFF;
        bus.ctrl_instruction = '0;
        bus.read_done        = 1'b0;
        bus.data_tvalid      = 1'b0;
        bus.data_tlast       = 1'b0;
        bus.data_tdata       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.ap_done), 64'd0);
        chk("rst_tready", 64'(bus.data_tready), 64'd0);
        chk("rst_read_start", 64'(bus.read_start), 64'd0);
        chk("rst_wr_valid", 64'(bus.buf_wr_valid), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_err), 64'd0);
        chk("rst_dram_addr", bus.dram_xfer_start_addr, 64'd0);
        chk("rst_dram_bytes", 64'(bus.dram_xfer_size_in_bytes), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) do_op(tv[i], i);

        // reset in the middle of a stream
        bus.ctrl_instruction = {16'h0200, 16'h0000, 16'd8, 16'h0080, 32'h0};
        bus.ap_start = 1'b1;
        @(posedge clk); #1;
        bus.ap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_t e;
            logic [511:0] p;
            p      = pat(20, i);
            e.mask = 4'b0001;
            e.addr = 9'(9'h080 + 9'(i));
            e.data = p[63:0];
            sbq.push_back(e);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("mid_tready", 64'(bus.data_tready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            bus.data_tvalid = 1'b1;
            bus.data_tdata  = pat(20, i);
            @(posedge clk); #1;
        end
        bus.data_tvalid = 1'b0;
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_tready", 64'(bus.data_tready), 64'd0);
        chk("mid_rst_wr_valid", 64'(bus.buf_wr_valid), 64'd0);
        chk("mid_rst_done", 64'(bus.ap_done), 64'd0);
        chk("mid_rst_dram_addr", bus.dram_xfer_start_addr, 64'd0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_idle", 64'(bus.busy), 64'd0);

        do_op(tv[0], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
